// File: rtl/ddc_pkg.sv
// Shared constants and the output saturation helper for the I/Q down-converter.
package ddc_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int PHASE_W = 24;
  localparam int ACC_W   = 48;

  // Distance from sine to cosine: a quarter of the LUT period.
  localparam logic [ADDR_W-1:0] QUARTER_OFFSET = 16'h4000;

  typedef struct packed {
    logic        sat;
    logic [15:0] val;
  } sat_t;

  // Clamp a signed value to the 16-bit output range and report whether it clipped.
  function automatic sat_t sat16(input logic signed [63:0] x);
    sat_t r;
    if (x > 64'sd32767) begin
      r.sat = 1'b1;
      r.val = 16'h7FFF;
    end else if (x < -64'sd32768) begin
      r.sat = 1'b1;
      r.val = 16'h8000;
    end else begin
      r.sat = 1'b0;
      r.val = x[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dual_read_sine_lut.sv
// Writable sine table with one write port and two registered read ports; reads return
// the pre-write contents when the same address is written in the same cycle.
module dual_read_sine_lut #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Table storage; contents survive reset so a loaded waveform is kept.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Both read ports sample the old contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    rdata_a <= mem_r[raddr_a];
    rdata_b <= mem_r[raddr_b];
  end

endmodule

// File: rtl/ddc_iq_demod.sv
// Digital down-converter: NCO mixing of ADC samples to I/Q followed by an
// integrate-and-dump decimator with shift and saturation at the output.
module ddc_iq_demod
  import ddc_pkg::*;
#(
  parameter int DataWidth    = DATA_W,
  parameter int AddressWidth = ADDR_W,
  parameter int AccWidth     = ACC_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic signed [DataWidth-1:0] SampleIn,
  input  logic                        SampleInValid,
  input  logic [31:0]                 FreqCntrl,
  input  logic [31:0]                 PhaseCntrl,
  input  logic [15:0]                 DecimCntrl,
  input  logic [5:0]                  ShiftCntrl,
  input  logic                        LUTWe,
  input  logic [31:0]                 LUTAddress,
  input  logic [31:0]                 LUTData,
  output logic signed [DataWidth-1:0] OutI,
  output logic signed [DataWidth-1:0] OutQ,
  output logic                        OutValid,
  output logic                        SatFlag
);

  localparam int PROD_W = 2 * DataWidth;
  localparam logic [AddressWidth-1:0] QOFF = {2'b01, {(AddressWidth-2){1'b0}}};

  logic [PHASE_W-1:0]          accu_r;
  logic [PHASE_W-1:0]          phase_r;
  logic signed [DataWidth-1:0] smp1_r;
  logic signed [DataWidth-1:0] smp2_r;
  logic                        v1_r;
  logic                        v2_r;
  logic                        v3_r;
  logic [AddressWidth-1:0]     sin_addr_s;
  logic [AddressWidth-1:0]     cos_addr_s;
  logic [DataWidth-1:0]        sin_raw_s;
  logic [DataWidth-1:0]        cos_raw_s;
  logic signed [DataWidth-1:0] sin_s;
  logic signed [DataWidth-1:0] cos_s;
  logic signed [PROD_W-1:0]    prod_i_r;
  logic signed [PROD_W-1:0]    prod_s_r;
  logic signed [AccWidth-1:0]  acc_i_r;
  logic signed [AccWidth-1:0]  acc_q_r;
  logic signed [AccWidth-1:0]  next_i_s;
  logic signed [AccWidth-1:0]  next_q_s;
  logic signed [AccWidth-1:0]  sum_i_r;
  logic signed [AccWidth-1:0]  sum_q_r;
  logic signed [AccWidth-1:0]  sh_i_s;
  logic signed [AccWidth-1:0]  sh_q_s;
  logic [15:0]                 count_r;
  logic [15:0]                 decim_r;
  logic [15:0]                 decim_now_s;
  logic [15:0]                 blk_n_s;
  logic                        last_s;
  logic                        dump_r;
  sat_t                        sat_i_s;
  sat_t                        sat_q_s;
  logic                        unused_s;

  assign unused_s = ^{FreqCntrl[31:PHASE_W], PhaseCntrl[31:PHASE_W],
                      LUTAddress[31:AddressWidth], LUTData[31:DataWidth], phase_r[7:0]};

  // S1: phase accumulator advances only on accepted samples; the sample uses the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accu_r  <= {PHASE_W{1'b0}};
      phase_r <= {PHASE_W{1'b0}};
      smp1_r  <= {DataWidth{1'b0}};
      v1_r    <= 1'b0;
    end else if (!en) begin
      accu_r  <= {PHASE_W{1'b0}};
      v1_r    <= 1'b0;
    end else begin
      v1_r <= SampleInValid;
      if (SampleInValid) begin
        phase_r <= accu_r + PhaseCntrl[PHASE_W-1:0];
        accu_r  <= accu_r + FreqCntrl[PHASE_W-1:0];
        smp1_r  <= SampleIn;
      end
    end
  end

  assign sin_addr_s = phase_r[AddressWidth+7:8];
  assign cos_addr_s = sin_addr_s + QOFF;

  dual_read_sine_lut #(
    .DATA_W (DataWidth),
    .ADDR_W (AddressWidth)
  ) u_lut (
    .clk     (clk),
    .we      (LUTWe),
    .waddr   (LUTAddress[AddressWidth-1:0]),
    .wdata   (LUTData[DataWidth-1:0]),
    .raddr_a (sin_addr_s),
    .raddr_b (cos_addr_s),
    .rdata_a (sin_raw_s),
    .rdata_b (cos_raw_s)
  );

  assign sin_s = signed'(sin_raw_s);
  assign cos_s = signed'(cos_raw_s);

  // S2/S3: delay the sample alongside the LUT read, then form both products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp2_r   <= {DataWidth{1'b0}};
      v2_r     <= 1'b0;
      prod_i_r <= {PROD_W{1'b0}};
      prod_s_r <= {PROD_W{1'b0}};
      v3_r     <= 1'b0;
    end else if (!en) begin
      v2_r <= 1'b0;
      v3_r <= 1'b0;
    end else begin
      smp2_r   <= smp1_r;
      v2_r     <= v1_r;
      prod_i_r <= smp2_r * cos_s;
      prod_s_r <= smp2_r * sin_s;
      v3_r     <= v2_r;
    end
  end

  // Block length is frozen at the first sample of each block; zero means one.
  assign decim_now_s = (DecimCntrl == 16'd0) ? 16'd1 : DecimCntrl;
  assign blk_n_s     = (count_r == 16'd0) ? decim_now_s : decim_r;
  assign last_s      = v3_r && (({1'b0, count_r} + 17'd1) == {1'b0, blk_n_s});
  assign next_i_s    = acc_i_r + AccWidth'(prod_i_r);
  assign next_q_s    = acc_q_r - AccWidth'(prod_s_r);

  // S4: integrate and hand the completed block sums to the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i_r <= {AccWidth{1'b0}};
      acc_q_r <= {AccWidth{1'b0}};
      sum_i_r <= {AccWidth{1'b0}};
      sum_q_r <= {AccWidth{1'b0}};
      count_r <= 16'd0;
      decim_r <= 16'd0;
      dump_r  <= 1'b0;
    end else if (!en) begin
      acc_i_r <= {AccWidth{1'b0}};
      acc_q_r <= {AccWidth{1'b0}};
      count_r <= 16'd0;
      decim_r <= 16'd0;
      dump_r  <= 1'b0;
    end else begin
      dump_r <= last_s;
      if (v3_r) begin
        if (count_r == 16'd0) begin
          decim_r <= decim_now_s;
        end
        if (last_s) begin
          sum_i_r <= next_i_s;
          sum_q_r <= next_q_s;
          acc_i_r <= {AccWidth{1'b0}};
          acc_q_r <= {AccWidth{1'b0}};
          count_r <= 16'd0;
        end else begin
          acc_i_r <= next_i_s;
          acc_q_r <= next_q_s;
          count_r <= count_r + 16'd1;
        end
      end
    end
  end

  assign sh_i_s  = sum_i_r >>> ShiftCntrl;
  assign sh_q_s  = sum_q_r >>> ShiftCntrl;
  assign sat_i_s = sat16(64'(sh_i_s));
  assign sat_q_s = sat16(64'(sh_q_s));

  // Output stage: scale, saturate and publish; results hold between dumps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutI     <= {DataWidth{1'b0}};
      OutQ     <= {DataWidth{1'b0}};
      OutValid <= 1'b0;
      SatFlag  <= 1'b0;
    end else if (!en) begin
      OutValid <= 1'b0;
      SatFlag  <= 1'b0;
    end else begin
      OutValid <= dump_r;
      if (dump_r) begin
        OutI    <= signed'(sat_i_s.val);
        OutQ    <= signed'(sat_q_s.val);
        SatFlag <= SatFlag | sat_i_s.sat | sat_q_s.sat;
      end
    end
  end

endmodule
